// File: rtl/ncc_peak_finder.sv
// Peak tracker for the ncc correlator: keeps best/second-best score and the
// raster offset of the best, then holds one result per search behind ready/valid.
module ncc_peak_finder #(
  parameter  int scoreWidth = 32,
  parameter  int numCols    = 65,
  parameter  int numRows    = 65,
  localparam int XW         = (numCols > 1) ? $clog2(numCols) : 1,
  localparam int YW         = (numRows > 1) ? $clog2(numRows) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic signed [scoreWidth-1:0] scoreIn,
  input  logic                         scoreValid,
  input  logic signed [scoreWidth-1:0] threshold,
  input  logic                         resultReady,
  output logic                         resultValid,
  output logic signed [scoreWidth-1:0] peakScore,
  output logic signed [scoreWidth-1:0] secondScore,
  output logic        [XW-1:0]         peakX,
  output logic        [YW-1:0]         peakY,
  output logic                         peakFound,
  output logic                         busy,
  output logic                         overrun
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic signed [scoreWidth-1:0] MOST_NEG = {1'b1, {(scoreWidth-1){1'b0}}};
  localparam logic [XW-1:0] X_LAST = XW'(numCols - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(numRows - 1);

  state_t                         r_state;
  state_t                         w_next;
  logic signed [scoreWidth-1:0]   r_peak;
  logic signed [scoreWidth-1:0]   r_second;
  logic        [XW-1:0]           r_px;
  logic        [YW-1:0]           r_py;
  logic        [XW-1:0]           r_x;
  logic        [YW-1:0]           r_y;
  logic                           r_found;
  logic                           r_overrun;

  logic                           w_clear;
  logic                           w_accept;
  logic                           w_last;
  logic                           w_gtPeak;
  logic                           w_gtSecond;
  logic signed [scoreWidth-1:0]   w_finalPeak;

  // A start in DONE only counts when the result is consumed in the same cycle.
  assign w_clear     = start && (r_state != DONE || resultReady);
  assign w_accept    = (r_state == SCAN) && scoreValid && !start;
  assign w_last      = w_accept && (r_x == X_LAST) && (r_y == Y_LAST);
  assign w_gtPeak    = scoreIn > r_peak;
  assign w_gtSecond  = scoreIn > r_second;
  assign w_finalPeak = w_gtPeak ? scoreIn : r_peak;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (start) w_next = SCAN;
      SCAN: if (start) w_next = SCAN;
            else if (w_last) w_next = DONE;
      DONE: if (resultReady) w_next = start ? SCAN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_peak    <= MOST_NEG;
      r_second  <= MOST_NEG;
      r_px      <= '0;
      r_py      <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_found   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (r_state == DONE && scoreValid) r_overrun <= 1'b1;
      if (w_clear) begin
        r_peak    <= MOST_NEG;
        r_second  <= MOST_NEG;
        r_px      <= '0;
        r_py      <= '0;
        r_x       <= '0;
        r_y       <= '0;
        r_overrun <= 1'b0;
      end else if (w_accept) begin
        if (w_gtPeak) begin
          r_second <= r_peak;
          r_peak   <= scoreIn;
          r_px     <= r_x;
          r_py     <= r_y;
        end else if (w_gtSecond) begin
          r_second <= scoreIn;
        end
        if (r_x == X_LAST) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
        // Threshold judged against the peak including this final score.
        if (w_last) r_found <= (w_finalPeak >= threshold);
      end
    end
  end

  assign resultValid = (r_state == DONE);
  assign busy        = (r_state == SCAN);
  assign peakScore   = r_peak;
  assign secondScore = r_second;
  assign peakX       = r_px;
  assign peakY       = r_py;
  assign peakFound   = r_found;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_ncc_peak_finder.sv
// Directed bench for ncc_peak_finder (4x2 search) with a list-based reference model.
module tb_ncc_peak_finder;

  localparam int SW = 32;
  localparam int NC = 4;
  localparam int NR = 2;
  localparam int N  = NC * NR;
  localparam logic signed [SW-1:0] MIN = 32'sh8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic signed [SW-1:0] scoreIn = '0;
  logic                 scoreValid = 1'b0;
  logic signed [SW-1:0] threshold = '0;
  logic                 resultReady = 1'b0;
  logic                 resultValid;
  logic signed [SW-1:0] peakScore;
  logic signed [SW-1:0] secondScore;
  logic [1:0]           peakX;
  logic [0:0]           peakY;
  logic                 peakFound;
  logic                 busy;
  logic                 overrun;

  ncc_peak_finder #(.scoreWidth(SW), .numCols(NC), .numRows(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .scoreIn(scoreIn), .scoreValid(scoreValid),
    .threshold(threshold), .resultReady(resultReady), .resultValid(resultValid),
    .peakScore(peakScore), .secondScore(secondScore), .peakX(peakX), .peakY(peakY),
    .peakFound(peakFound), .busy(busy), .overrun(overrun)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: accepted scores of the current search, plus mode flags.
  logic signed [SW-1:0] m_scores[$];
  bit m_scan, m_done, m_over, m_found;

  // Peak = first occurrence of the maximum; second = max of the rest.
  task automatic summarize(output logic signed [SW-1:0] pk, output logic signed [SW-1:0] sc,
                           output int idx);
    pk = MIN; sc = MIN; idx = 0;
    for (int i = 0; i < m_scores.size(); i++)
      if (m_scores[i] > pk) begin pk = m_scores[i]; idx = i; end
    for (int i = 0; i < m_scores.size(); i++)
      if (i != idx && m_scores[i] > sc) sc = m_scores[i];
  endtask

  always @(posedge clk) begin : model
    logic signed [SW-1:0] pk, sc;
    int idx;
    if (rst) begin
      m_scan = 0; m_done = 0; m_over = 0; m_found = 0;
      m_scores.delete();
    end else if (m_done) begin
      if (scoreValid) m_over = 1;
      if (resultReady) begin
        m_done = 0;
        if (start) begin m_scores.delete(); m_over = 0; m_scan = 1; end
      end
    end else if (m_scan) begin
      if (start) m_scores.delete();
      else if (scoreValid) begin
        m_scores.push_back(scoreIn);
        if (m_scores.size() == N) begin
          summarize(pk, sc, idx);
          m_found = (pk >= threshold);
          m_scan = 0; m_done = 1;
        end
      end
    end else if (start) begin
      m_scores.delete(); m_over = 0; m_scan = 1;
    end
  end

  always @(negedge clk) begin : compare
    logic signed [SW-1:0] pk, sc;
    int idx;
    if (cmp_en) begin
      summarize(pk, sc, idx);
      chk("resultValid", {31'b0, resultValid}, {31'b0, m_done});
      chk("busy",        {31'b0, busy},        {31'b0, m_scan});
      chk("overrun",     {31'b0, overrun},     {31'b0, m_over});
      chk("peakFound",   {31'b0, peakFound},   {31'b0, m_found});
      chk("peakScore",   peakScore,   pk);
      chk("secondScore", secondScore, sc);
      chk("peakX",       {30'b0, peakX}, 32'(idx % NC));
      chk("peakY",       {31'b0, peakY}, 32'(idx / NC));
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic feed(input logic signed [SW-1:0] s, input int gap);
    scoreIn = s; scoreValid = 1'b1;
    cyc();
    scoreValid = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  logic signed [SW-1:0] basic [N] = '{5, -3, 9, 2, 9, 7, 1, 0};
  logic signed [SW-1:0] negs  [N] = '{-10, -4, -7, -20, -9, -5, -6, -8};
  logic signed [SW-1:0] b2b   [N] = '{3, 1, 4, 1, 5, 9, 2, 6};
  logic signed [SW-1:0] held_peak;

  initial begin
    cyc();
    cmp_en = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();

    // Reset in the middle of a scan.
    pulse_start();
    feed(11, 0); feed(22, 0); feed(33, 0);
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst_rv",   {31'b0, resultValid}, 32'd0);
    chk("rst_busy", {31'b0, busy},        32'd0);
    chk("rst_peak", peakScore,            32'h8000_0000);
    for (int i = 0; i < N; i++) feed(40 + i, 0);
    cyc();
    chk("rst_noresult", {31'b0, resultValid}, 32'd0);

    // Basic peak with idle gaps, tie keeps first.
    threshold = 8;
    pulse_start();
    for (int i = 0; i < N; i++) feed(basic[i], (i == N-1) ? 0 : 1);
    chk("basic_rv",     {31'b0, resultValid}, 32'd1);
    chk("basic_peak",   peakScore,   32'd9);
    chk("basic_second", secondScore, 32'd9);
    chk("basic_x",      {30'b0, peakX}, 32'd2);
    chk("basic_y",      {31'b0, peakY}, 32'd0);
    chk("basic_found",  {31'b0, peakFound}, 32'd1);
    resultReady = 1'b1; cyc(); resultReady = 1'b0;
    chk("basic_idle_rv", {31'b0, resultValid}, 32'd0);
    chk("basic_hold",    peakScore, 32'd9);

    // All negative scores against threshold 0.
    threshold = 0;
    pulse_start();
    for (int i = 0; i < N; i++) feed(negs[i], 0);
    chk("neg_peak",   peakScore,   32'hFFFF_FFFC);
    chk("neg_second", secondScore, 32'hFFFF_FFFB);
    chk("neg_x",      {30'b0, peakX}, 32'd1);
    chk("neg_y",      {31'b0, peakY}, 32'd0);
    chk("neg_found",  {31'b0, peakFound}, 32'd0);

    // Hold in DONE, then an overrun score.
    held_peak = peakScore;
    threshold = 1234;
    repeat (5) cyc();
    chk("hold_rv",   {31'b0, resultValid}, 32'd1);
    chk("hold_peak", peakScore, held_peak);
    feed(1000, 0);
    chk("ovr_set",  {31'b0, overrun}, 32'd1);
    chk("ovr_peak", peakScore, 32'hFFFF_FFFC);
    resultReady = 1'b1; cyc(); resultReady = 1'b0;
    chk("ovr_idle_rv",  {31'b0, resultValid}, 32'd0);
    chk("ovr_sticky",   {31'b0, overrun},     32'd1);

    // Restart mid-scan; the score coincident with start is dropped.
    threshold = 50;
    pulse_start();
    chk("ovr_cleared", {31'b0, overrun}, 32'd0);
    feed(3, 0); feed(100, 0); feed(4, 0); feed(5, 0); feed(6, 0);
    start = 1'b1; scoreValid = 1'b1; scoreIn = 500;
    cyc();
    start = 1'b0; scoreValid = 1'b0;
    chk("restart_busy", {31'b0, busy}, 32'd1);
    chk("restart_peak", peakScore, 32'h8000_0000);
    for (int i = 0; i < N; i++) feed(1, 0);
    chk("restart_peak1",  peakScore,   32'd1);
    chk("restart_second", secondScore, 32'd1);
    chk("restart_x",      {30'b0, peakX}, 32'd0);
    chk("restart_y",      {31'b0, peakY}, 32'd0);
    chk("restart_found",  {31'b0, peakFound}, 32'd0);

    // Back-to-back: handshake and start in the same cycle; threshold equals peak.
    resultReady = 1'b1; start = 1'b1;
    cyc();
    resultReady = 1'b0; start = 1'b0;
    chk("b2b_busy", {31'b0, busy},        32'd1);
    chk("b2b_rv",   {31'b0, resultValid}, 32'd0);
    threshold = 9;
    for (int i = 0; i < N; i++) feed(b2b[i], 0);
    chk("b2b_peak",   peakScore,   32'd9);
    chk("b2b_second", secondScore, 32'd6);
    chk("b2b_x",      {30'b0, peakX}, 32'd1);
    chk("b2b_y",      {31'b0, peakY}, 32'd1);
    chk("b2b_found",  {31'b0, peakFound}, 32'd1);
    resultReady = 1'b1; cyc(); resultReady = 1'b0;
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ncc_peak_finder.md
Name: ncc_peak_finder

Overview:
- Sits directly downstream of the ncc correlator.
- Consumes one signed correlation score per window offset, in raster order, and tracks the best and second-best scores plus the (x,y) offset of the best.
- Presents a single held result per search, with a ready/valid handshake, to the match-reporting logic.
- Reports a threshold pass flag and a sticky overrun flag.

Parameters:
- scoreWidth, 32, width of the signed two's-complement correlation score.
- numCols, 65, horizontal offsets per search row; x counts 0..numCols-1.
- numRows, 65, vertical offsets per search; y counts 0..numRows-1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that clears trackers and begins a new search.
- scoreIn  input  scoreWidth  signed score for the current offset.
- scoreValid  input  1  scoreIn is valid this cycle. There is no input backpressure.
- threshold  input  scoreWidth  signed acceptance threshold, sampled when the result is produced.
- resultReady  input  1  consumer accepts the result.
- resultValid  output  1  result fields are valid and held.
- peakScore  output  scoreWidth  best score of the search.
- secondScore  output  scoreWidth  second-best score of the search.
- peakX  output  $clog2(numCols)  x of the best score.
- peakY  output  $clog2(numRows)  y of the best score.
- peakFound  output  1  peakScore >= threshold (signed compare).
- busy  output  1  high in SCAN.
- overrun  output  1  sticky error flag.

Behaviour:
- Reset (rst=1 at posedge, overrides everything, including mid-scan):
  - state=IDLE.
  - resultValid=0, busy=0, overrun=0, peakFound=0.
  - peakScore=secondScore=most-negative value (1 followed by zeros).
  - peakX=peakY=0; x and y counters = 0.
- States are IDLE, SCAN and DONE.
- IDLE:
  - scoreValid is ignored and does not set overrun.
  - start moves to SCAN next cycle. It clears peak/second to most-negative, peakX/peakY/x/y to 0, and overrun to 0.
  - A score presented in the same cycle as start is not counted.
- SCAN:
  - busy=1.
  - Each cycle with scoreValid=1 accepts scoreIn at the current (x,y) and updates the trackers as follows:
    - If scoreIn > peakScore (signed, strict): secondScore<=peakScore, peakScore<=scoreIn, peakX<=x, peakY<=y.
    - Else if scoreIn > secondScore: secondScore<=scoreIn.
    - Ties keep the earlier (first-in-raster) peak.
  - Offset counters advance after each accepted score: x increments; at x=numCols-1 it wraps to 0 and y increments.
  - When the accepted score has x=numCols-1 and y=numRows-1, the next cycle is DONE with resultValid=1. Latency from last accepted score to resultValid is 1 cycle.
  - peakFound is registered on the same edge, using the final peakScore (including the last score) against threshold.
  - A start in SCAN restarts: clears as from IDLE, stays in SCAN, and discards any scoreValid that cycle.
- DONE:
  - resultValid=1; all result outputs are held stable.
  - resultValid=1 && resultReady=1 goes to IDLE next cycle. Result fields keep their values; resultValid drops.
  - scoreValid=1 in DONE discards the score and sets overrun=1. overrun stays set until the next start or rst.
  - start in DONE is ignored unless resultReady=1 in the same cycle. In that case the handshake completes and the block goes directly to SCAN with clears applied.
- Arithmetic:
  - All comparisons are signed at scoreWidth. No saturation is needed.
  - Counters are sized from the parameters and never exceed numCols-1 / numRows-1.
- numCols=1 or numRows=1 must work: x or y stays 0, and a counter of width 0 is treated as 1 bit tied to 0.

Test Plan:
- Reset mid-scan: numCols=4, numRows=2; start, feed 3 scores, assert rst -> next cycle resultValid=0, busy=0, peakScore=32'h8000_0000; the following 8 scores without start produce no result.
- Basic peak: numCols=4, numRows=2; start, scores 5,-3,9,2,9,7,1,0 with gaps of idle cycles -> resultValid one cycle after the 8th score; peakScore=9, peakX=2, peakY=0 (tie keeps first), secondScore=9, peakFound=1 with threshold=8.
- All negative: scores -10,-4,-7,-20,-9,-5,-6,-8, threshold=0 -> peakScore=-4 at (1,0), secondScore=-5, peakFound=0.
- Handshake hold: hold resultReady=0 for 5 cycles -> outputs are stable and resultValid stays 1; a scoreValid pulse in DONE sets overrun=1; resultReady=1 -> IDLE next cycle; the next start clears overrun.
- Restart in SCAN: after 5 scores (peak 100), pulse start with scoreValid=1 and scoreIn=500 -> that score is discarded; a new 8-score search of all 1s yields peakScore=1 at (0,0), secondScore=1.
- Back-to-back: in DONE, assert resultReady and start together -> next cycle busy=1, resultValid=0; the second search completes independently with correct results.
